// File: rtl/mc_alu_sequencer_if.sv
// ALU/datapath control bundle between the multi-cycle main controller (master)
// and the datapath/ALU side (slave).
interface mc_alu_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       epc_write;
  logic       cause_write;
  logic [4:0] cause_code;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct, zero, overflow,
    output alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
           epc_write, cause_write, cause_code, state_dbg
  );

  modport slave (
    output opcode, funct, zero, overflow,
    input  alu_control, alu_src_a, alu_src_b, iord, mem_read, mem_write,
           ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg,
           epc_write, cause_write, cause_code, state_dbg
  );
endinterface

// File: rtl/mc_alu_sequencer.sv
// Multi-cycle MIPS main control FSM driving the ALU and datapath strobes.
// Optional jump support is enabled by defining MC_ALU_SEQ_JUMP_EN.
//
// state     | meaning
// IDLE      | reset, all outputs low
// FETCH     | read instruction, PC <= PC+4
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | lw/sw effective address
// MEM_READ  | load data into MDR
// MEM_WB    | MDR -> rt
// MEM_WRITE | store B to memory
// R_EXEC    | R-type ALU operation
// R_WB      | ALUOut -> rd
// BRANCH    | compare A/B, conditionally load PC
// I_EXEC    | addi ALU operation
// I_WB      | ALUOut -> rt
// EXCEPT    | EPC/Cause load, PC <= exception vector
// JUMP      | PC <= jump target (only with jump support)
module mc_alu_sequencer #(
  parameter logic [4:0] EXC_CAUSE_OVF = 5'd12,
  parameter logic [4:0] EXC_CAUSE_RI  = 5'd10
) (
  input logic               clk,
  input logic               rst_n,
  mc_alu_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
`ifdef MC_ALU_SEQ_JUMP_EN
    S_JUMP      = 4'd13,
`endif
    S_EXCEPT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_ALU_SEQ_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  state_t     state, state_next;
  logic [4:0] cause_q, cause_next;

  logic [3:0] r_alu;
  logic       r_valid;
  logic       r_arith;

  always_comb begin
    r_alu   = ALU_ADD;
    r_valid = 1'b1;
    r_arith = 1'b0;
    case (bus.funct)
      FN_ADD:  begin r_alu = ALU_ADD; r_arith = 1'b1; end
      FN_SUB:  begin r_alu = ALU_SUB; r_arith = 1'b1; end
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      default: r_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cause_q <= 5'd0;
    end else begin
      state <= state_next;
      if (state_next == S_EXCEPT)
        cause_q <= cause_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:   state_next = S_MEM_ADDR;
          OP_RTYPE:       state_next = S_R_EXEC;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI:        state_next = S_I_EXEC;
`ifdef MC_ALU_SEQ_JUMP_EN
          OP_J:           state_next = S_JUMP;
`endif
          default: begin
            state_next = S_EXCEPT;
            cause_next = EXC_CAUSE_RI;
          end
        endcase
      end
      S_MEM_ADDR: state_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: state_next = S_MEM_WB;
      S_R_EXEC: begin
        if (!r_valid) begin
          state_next = S_EXCEPT;
          cause_next = EXC_CAUSE_RI;
        end else if (r_arith && bus.overflow) begin
          state_next = S_EXCEPT;
          cause_next = EXC_CAUSE_OVF;
        end else begin
          state_next = S_R_WB;
        end
      end
      S_I_EXEC: begin
        if (bus.overflow) begin
          state_next = S_EXCEPT;
          cause_next = EXC_CAUSE_OVF;
        end else begin
          state_next = S_I_WB;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  logic [3:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord, mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write, reg_dst, mem_to_reg, epc_write, cause_write;
  logic [4:0] cause_code;

  // Moore decode; only BRANCH's pc_write looks at the live zero flag.
  always_comb begin
    alu_control = 4'b0000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    epc_write   = 1'b0;
    cause_write = 1'b0;
    cause_code  = 5'd0;
    case (state)
      S_FETCH: begin
        mem_read    = 1'b1;
        ir_write    = 1'b1;
        pc_write    = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_b   = 2'd3;
        alu_control = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = r_alu;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'd1;
        pc_write    = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
      end
      S_EXCEPT: begin
        epc_write   = 1'b1;
        cause_write = 1'b1;
        pc_write    = 1'b1;
        pc_src      = 2'd3;
        cause_code  = cause_q;
      end
`ifdef MC_ALU_SEQ_JUMP_EN
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
      end
`endif
      default: ;
    endcase
  end

  assign bus.alu_control = alu_control;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.iord        = iord;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.reg_write   = reg_write;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.epc_write   = epc_write;
  assign bus.cause_write = cause_write;
  assign bus.cause_code  = cause_code;
  assign bus.state_dbg   = state;

endmodule
